// File: rtl/qspi_slave_port.sv
// qspi_slave_port
// Quad-SPI slave front end for the shared 8-bit mailbox RAM. The host pins are
// oversampled in the clk domain and decoded into command/address/data frames.
// RAM writes are single-cycle pulses. RAM reads are synchronous, with data
// valid one clk after ram_addr.
//
// Ports
//   clk, rst_n            system clock, async active-low reset
//   qspi_sck/cs_n/io_in   host pins (mode 0, sck idle low)
//   qspi_io_out/io_oe     pin drive value and output enable
//   ram_addr/wdata/wen    RAM write/address port
//   ram_rdata             RAM read data
//   busy                  frame selected (synchronized cs_n low, 1 clk delay)
//   frame_done            one-cycle pulse after synchronized cs_n rises
//
// Build option: define QSPI_READBACK_EN to enable the 0xEB quad-read path.
// Without it, 0xEB is ignored like any other unknown command and the pins
// are never driven.
module qspi_slave_port #(
  parameter int addr_width = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  qspi_sck,
  input  logic                  qspi_cs_n,
  input  logic [3:0]            qspi_io_in,
  output logic [3:0]            qspi_io_out,
  output logic                  qspi_io_oe,
  output logic [addr_width-1:0] ram_addr,
  output logic [7:0]            ram_wdata,
  output logic                  ram_wen,
  input  logic [7:0]            ram_rdata,
  output logic                  busy,
  output logic                  frame_done
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CMD    = 3'd1;
  localparam logic [2:0] ST_ADDR   = 3'd2;
  localparam logic [2:0] ST_DUMMY  = 3'd3;
  localparam logic [2:0] ST_WDATA  = 3'd4;
  localparam logic [2:0] ST_RDATA  = 3'd5;
  localparam logic [2:0] ST_IGNORE = 3'd6;

  logic       sck_s1_q, sck_s2_q, sck_s3_q;
  logic       cs_s1_q, cs_s2_q;
  logic [3:0] io_s1_q, io_s2_q;
  logic [1:0] sync_ok_q;

  // The cs_n synchronizer resets to "deselected". sync_ok_q marks when the
  // chain holds real pin samples, so a cs_n held low across reset is not
  // mistaken for a fresh falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_s1_q  <= 1'b0;
      sck_s2_q  <= 1'b0;
      sck_s3_q  <= 1'b0;
      cs_s1_q   <= 1'b1;
      cs_s2_q   <= 1'b1;
      io_s1_q   <= 4'h0;
      io_s2_q   <= 4'h0;
      sync_ok_q <= 2'b00;
    end else begin
      sck_s1_q  <= qspi_sck;
      sck_s2_q  <= sck_s1_q;
      sck_s3_q  <= sck_s2_q;
      cs_s1_q   <= qspi_cs_n;
      cs_s2_q   <= cs_s1_q;
      io_s1_q   <= qspi_io_in;
      io_s2_q   <= io_s1_q;
      sync_ok_q <= {sync_ok_q[0], 1'b1};
    end
  end

  logic sck_rise, sck_fall;
  assign sck_rise = sck_s2_q & ~sck_s3_q;
  assign sck_fall = ~sck_s2_q & sck_s3_q;

  logic [2:0]            state_q, state_d;
  logic                  nib_q, nib_d;
  logic [3:0]            hi_q, hi_d;
  logic                  is_read_q, is_read_d;
  logic [addr_width-1:0] addr_q, addr_d;
  logic                  wen_q, wen_d;
  logic [7:0]            wdata_q, wdata_d;
  logic [3:0]            tx_lo_q, tx_lo_d;
  logic                  tx_nib_q, tx_nib_d;
  logic [3:0]            io_out_q, io_out_d;
  logic                  oe_q, oe_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  cs_prev_q, cs_prev_d;
  logic                  armed_q, armed_d;
  logic [7:0]            rx_byte;

  assign rx_byte = {hi_q, io_s2_q};

  always_comb begin
    state_d   = state_q;
    nib_d     = nib_q;
    hi_d      = hi_q;
    is_read_d = is_read_q;
    addr_d    = addr_q;
    wen_d     = 1'b0;
    wdata_d   = wdata_q;
    tx_lo_d   = tx_lo_q;
    tx_nib_d  = tx_nib_q;
    io_out_d  = io_out_q;
    oe_d      = oe_q;
    busy_d    = ~cs_s2_q;
    done_d    = cs_s2_q & ~cs_prev_q;
    cs_prev_d = cs_s2_q;
    // Only accept a frame once cs_n has been seen high after reset.
    armed_d   = armed_q | (sync_ok_q[1] & cs_s2_q);

    // Advance the address the cycle after each write pulse, so ram_addr is
    // stable while ram_wen is high.
    if (wen_q) addr_d = addr_q + addr_width'(1);

    if (cs_s2_q) begin
      // Deselect aborts everything; a half-received byte is dropped.
      state_d  = ST_IDLE;
      nib_d    = 1'b0;
      tx_nib_d = 1'b0;
      oe_d     = 1'b0;
      io_out_d = 4'h0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          nib_d = 1'b0;
          if (armed_q) state_d = ST_CMD;
        end
        ST_RDATA: begin
          // The high nibble comes straight from ram_rdata. The address was
          // bumped at least one sck half-period earlier, so the prefetched
          // byte is already valid.
          if (sck_fall) begin
            oe_d = 1'b1;
            if (!tx_nib_q) begin
              io_out_d = ram_rdata[7:4];
              tx_lo_d  = ram_rdata[3:0];
              tx_nib_d = 1'b1;
            end else begin
              io_out_d = tx_lo_q;
              tx_nib_d = 1'b0;
              addr_d   = addr_q + addr_width'(1);
            end
          end
        end
        default: begin
          if (sck_rise) begin
            nib_d = ~nib_q;
            if (!nib_q) begin
              hi_d = io_s2_q;
            end else begin
              case (state_q)
                ST_CMD: begin
                  if (rx_byte == 8'h38) begin
                    is_read_d = 1'b0;
                    state_d   = ST_ADDR;
`ifdef QSPI_READBACK_EN
                  end else if (rx_byte == 8'hEB) begin
                    is_read_d = 1'b1;
                    state_d   = ST_ADDR;
`endif
                  end else begin
                    state_d = ST_IGNORE;
                  end
                end
                ST_ADDR: begin
                  addr_d  = rx_byte[addr_width-1:0];
                  state_d = is_read_q ? ST_DUMMY : ST_WDATA;
                end
                ST_DUMMY: begin
                  state_d  = ST_RDATA;
                  tx_nib_d = 1'b0;
                end
                ST_WDATA: begin
                  wen_d   = 1'b1;
                  wdata_d = rx_byte;
                end
                default: ;
              endcase
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      nib_q     <= 1'b0;
      hi_q      <= 4'h0;
      is_read_q <= 1'b0;
      addr_q    <= '0;
      wen_q     <= 1'b0;
      wdata_q   <= 8'h00;
      tx_lo_q   <= 4'h0;
      tx_nib_q  <= 1'b0;
      io_out_q  <= 4'h0;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cs_prev_q <= 1'b1;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      nib_q     <= nib_d;
      hi_q      <= hi_d;
      is_read_q <= is_read_d;
      addr_q    <= addr_d;
      wen_q     <= wen_d;
      wdata_q   <= wdata_d;
      tx_lo_q   <= tx_lo_d;
      tx_nib_q  <= tx_nib_d;
      io_out_q  <= io_out_d;
      oe_q      <= oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cs_prev_q <= cs_prev_d;
      armed_q   <= armed_d;
    end
  end

  assign ram_addr   = addr_q;
  assign ram_wdata  = wdata_q;
  assign ram_wen    = wen_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

`ifdef QSPI_READBACK_EN
  assign qspi_io_out = io_out_q;
  assign qspi_io_oe  = oe_q;
`else
  // Write-only build: the read datapath is unreachable and the pins stay
  // undriven.
  logic unused_rd;
  assign unused_rd   = ^{io_out_q, oe_q};
  assign qspi_io_out = 4'h0;
  assign qspi_io_oe  = 1'b0;
`endif

endmodule
